// File: rtl/addsub_seq_ctrl.sv
// Byte-serial multi-precision add/subtract sequencer. It runs one 8-bit slice per clock and chains the carry through a flop.
// Latency: NBYTES+1 cycles from the accepted start to done, or NBYTES+2 when SEQ_SAT_EN is defined (adds the SAT state).
// Backpressure: none. A start is taken only in IDLE; starts seen in any other state are dropped and not queued.
module addsub_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  op_i,
    input  logic [8*NBYTES-1:0]   a_i,
    input  logic [8*NBYTES-1:0]   b_i,
    input  logic                  carryin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [8*NBYTES-1:0]   result_o,
    output logic                  carryout_o
);

    localparam int W  = 8 * NBYTES;
    localparam int KW = $clog2(NBYTES);
    localparam logic [KW-1:0] LAST_K = KW'(NBYTES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
`ifdef SEQ_SAT_EN
    localparam logic [1:0] SAT  = 2'd2;
`endif
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          op_q, op_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  result_q, result_d;
    logic          carryout_q, carryout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [7:0]    byte_y;
    logic [8:0]    sum9;

    // Shared 8-bit slice. Subtract feeds ~B, and the carry flop starts at 1 to supply the +1.
    always_comb begin
        byte_y = op_q ? b_q[k_q*8 +: 8] : ~b_q[k_q*8 +: 8];
        sum9   = {1'b0, a_q[k_q*8 +: 8]} + {1'b0, byte_y} + {8'd0, carry_q};
    end

    // Next-state logic. Result bytes are updated in place, LSB first.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        carry_d    = carry_q;
        result_d   = result_q;
        carryout_d = carryout_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    op_d    = op_i;
                    carry_d = op_i ? carryin_i : 1'b1;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[k_q*8 +: 8] = sum9[7:0];
                carry_d              = sum9[8];
                if (k_q == LAST_K) begin
                    k_d        = '0;
                    // Load carryout here so that it is already valid in the done cycle.
                    carryout_d = sum9[8];
`ifdef SEQ_SAT_EN
                    state_d    = SAT;
`else
                    state_d    = DONE;
                    done_d     = 1'b1;
`endif
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
`ifdef SEQ_SAT_EN
            SAT: begin
                // Clamp the result. carryout keeps the unsaturated carry.
                if (op_q && carry_q) begin
                    result_d = '1;
                end else if (!op_q && !carry_q) begin
                    result_d = '0;
                end
                state_d = DONE;
                done_d  = 1'b1;
            end
`endif
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers. An asynchronous reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= 1'b0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            carryout_q <= carryout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign carryout_o = carryout_q;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Testbench for addsub_seq_ctrl with NBYTES=4. It covers reset, directed vectors, random operations against a 33-bit arithmetic model,
// starts issued while busy or done, and a reset in the middle of an operation.
// Inputs are driven 1ns after the rising edge, and outputs are sampled at that same point.
module tb_addsub_seq_ctrl;

    localparam int NB = 4;
`ifdef SEQ_SAT_EN
    localparam int LAT = NB + 2;
`else
    localparam int LAT = NB + 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;

    int tests = 0;
    int fails = 0;

    addsub_seq_ctrl #(.NBYTES(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .carryin_i  (cin),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result),
        .carryout_o (cout)
    );

    always #5 clk = ~clk;

    // Reference model: full-width arithmetic. The return value is {carry, result}.
    function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mop, input logic mcin);
        logic [32:0] s;
        if (mop) s = {1'b0, ma} + {1'b0, mb} + {32'd0, mcin};
        else     s = {1'b0, ma} + {1'b0, ~mb} + 33'd1;
`ifdef SEQ_SAT_EN
        if (mop && s[32])   s[31:0] = 32'hFFFF_FFFF;
        if (!mop && !s[32]) s[31:0] = 32'h0;
`endif
        return s;
    endfunction

    // Issue one operation and wait for done. The inputs are scrambled while the operation runs.
    // On return the bench is one cycle past done, so the block is idle again.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                          input logic tcin, output logic [31:0] res, output logic co,
                          output int lat, output bit seen);
        a = ta; b = tb; op = top; cin = tcin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1; seen = 1'b0; res = '0; co = 1'b0;
        while (lat <= 20) begin
            if (done === 1'b1) begin
                seen = 1'b1; res = result; co = cout;
                break;
            end
            a = $urandom; b = $urandom; op = 1'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
        tests++; if (result !== 32'h0)  begin fails++; $display("FAIL reset_result got=%h exp=0", result); end
        tests++; if (cout !== 1'b0)     begin fails++; $display("FAIL reset_carryout got=%b exp=0", cout); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0)
            begin fails++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy, done); end
    endtask

    task automatic test_directed;
        logic [31:0] va[4]  = '{32'h00FF_FFFF, 32'hFFFF_FFFF, 32'h0000_0010, 32'h1234_5678};
        logic [31:0] vb[4]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0020, 32'h0234_5678};
        logic        vop[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic        vci[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef SEQ_SAT_EN
        logic [31:0] er[4]  = '{32'h0100_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1000_0000};
`else
        logic [31:0] er[4]  = '{32'h0100_0000, 32'h0000_0000, 32'hFFFF_FFF0, 32'h1000_0000};
`endif
        logic        ec[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] r; logic c; int lat; bit seen;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vop[i], vci[i], r, c, lat, seen);
            tests++; if (!seen || lat != LAT)
                begin fails++; $display("FAIL dir%0d_latency got=%0d seen=%0b exp=%0d", i, lat, seen, LAT); end
            tests++; if (r !== er[i])
                begin fails++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, er[i]); end
            tests++; if (c !== ec[i])
                begin fails++; $display("FAIL dir%0d_carryout got=%b exp=%b", i, c, ec[i]); end
        end
    endtask

    task automatic test_random;
        logic [31:0] ra, rb, r; logic rop, rci, c; logic [32:0] e; int lat; bit seen;
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rop = 1'($urandom); rci = 1'($urandom);
            if (i % 8 == 0) rb = ra;            // equal operands: subtract must leave no borrow
            if (i % 8 == 1) ra = 32'hFFFF_FFFF;
            e = model(ra, rb, rop, rci);
            run_op(ra, rb, rop, rci, r, c, lat, seen);
            tests++; if (!seen || r !== e[31:0] || c !== e[32] || lat != LAT)
                begin fails++; $display("FAIL rand%0d a=%h b=%h op=%b ci=%b got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                                        i, ra, rb, rop, rci, r, c, lat, e[31:0], e[32], LAT); end
        end
    endtask

    task automatic test_back_to_back;
        logic [32:0] e1, e2; bit exp_done, exp_busy;
        e1 = model(32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        e2 = model(32'h8000_0001, 32'h0000_0003, 1'b0, 1'b0);
        a = 32'h1111_1111; b = 32'h2222_2222; op = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 2*LAT + 1; c++) begin
            exp_done = (c == LAT) || (c == 2*LAT + 1);
            exp_busy = (c != LAT + 1);
            tests++; if (done !== exp_done)
                begin fails++; $display("FAIL b2b_done cycle=%0d got=%b exp=%b", c, done, exp_done); end
            tests++; if (busy !== exp_busy)
                begin fails++; $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", c, busy, exp_busy); end
            if (c == LAT) begin
                tests++; if (result !== e1[31:0] || cout !== e1[32])
                    begin fails++; $display("FAIL b2b_first got=%h/%b exp=%h/%b", result, cout, e1[31:0], e1[32]); end
            end
            if (c == 2*LAT + 1) begin
                tests++; if (result !== e2[31:0] || cout !== e2[32])
                    begin fails++; $display("FAIL b2b_second got=%h/%b exp=%h/%b", result, cout, e2[31:0], e2[32]); end
            end
            if (c == 2 || c == LAT) begin
                a = 32'hDEAD_BEEF; b = 32'hFFFF_FFFF; op = 1'b0; start = 1'b1;
            end else if (c == LAT + 1) begin
                a = 32'h8000_0001; b = 32'h0000_0003; op = 1'b0; cin = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        logic [31:0] r; logic c; int lat; bit seen, spurious;
        a = 32'h00FF_FFFF; b = 32'h0000_0001; op = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || cout !== 1'b0)
            begin fails++; $display("FAIL midrst_clear busy=%b done=%b result=%h cout=%b exp=0", busy, done, result, cout); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
            @(posedge clk); #1;
        end
        tests++; if (spurious)
            begin fails++; $display("FAIL midrst_no_done got=activity exp=idle"); end
        run_op(32'h00FF_FFFF, 32'h0000_0001, 1'b1, 1'b0, r, c, lat, seen);
        tests++; if (!seen || r !== 32'h0100_0000 || c !== 1'b0 || lat != LAT)
            begin fails++; $display("FAIL midrst_fresh got=%h/%b lat=%0d exp=01000000/0 lat=%0d", r, c, lat, LAT); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_mid_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
